// File: rtl/edit_mode_ctrl_pkg.sv
// Shared types and constants for the user-edit session sequencer.
// Field codes follow the display order of the clock/date and timer groups.
package edit_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EDIT_CLK = 2'd1,
        S_EDIT_TMR = 2'd2,
        S_COMMIT   = 2'd3
    } state_e;

    localparam logic [2:0] F_SEG  = 3'd0;
    localparam logic [2:0] F_MIN  = 3'd1;
    localparam logic [2:0] F_HORA = 3'd2;
    localparam logic [2:0] F_DIA  = 3'd3;
    localparam logic [2:0] F_MES  = 3'd4;
    localparam logic [2:0] F_ANO  = 3'd5;

    localparam int unsigned N_CLK_FIELDS = 6;
    localparam int unsigned N_TMR_FIELDS = 3;

    function automatic logic [2:0] next_field(input logic [2:0] cur, input logic is_clk);
        logic [2:0] last;
        last = is_clk ? 3'(N_CLK_FIELDS - 1) : 3'(N_TMR_FIELDS - 1);
        return (cur >= last) ? F_SEG : cur + 3'd1;
    endfunction

endpackage

// File: rtl/edit_mode_ctrl_tick_cnt.sv
// Period tick generator: down-counter reloaded to N-1, done pulses while enabled at zero.
// done ignores clr so a terminal count is never masked by a same-cycle restart.
module edit_tick_cnt #(
    parameter int unsigned N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int unsigned W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LOAD = W'(N - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done = en && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || done) begin
            cnt_d = LOAD;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/edit_mode_ctrl.sv
// User-edit session sequencer: selects user vs RTC data for the display mux,
// walks the edited field with a blink highlight, and commits via req/ack to the RTC writer.
//
//   state      | meaning
//   S_IDLE     | display shows RTC data; waits for a pending edit target and rtc_busy=0
//   S_EDIT_CLK | user edits clock/date fields 0..5
//   S_EDIT_TMR | user edits timer fields 0..2
//   S_COMMIT   | wr_req held to RTC writer until wr_ack; display keeps user data
module edit_mode_ctrl
    import edit_mode_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV   = 25_000_000,
    parameter int unsigned TIMEOUT_CYC = 1_500_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prog_clk_pls,
    input  logic       prog_tmr_pls,
    input  logic       next_pls,
    input  logic       ok_pls,
    input  logic       cancel_pls,
    input  logic       usr_activity,
    input  logic       rtc_busy,
    input  logic       wr_ack,
    output logic       En_Escr,
    output logic       En_clock,
    output logic [2:0] field_sel,
    output logic       blink,
    output logic       wr_req,
    output logic       wr_clk_sel,
    output logic       edit_abort
);

    state_e     state_q, state_d;
    logic       en_escr_q, en_escr_d;
    logic       en_clock_q, en_clock_d;
    logic [2:0] field_sel_q, field_sel_d;
    logic       blink_q, blink_d;
    logic       wr_req_q, wr_req_d;
    logic       wr_clk_sel_q, wr_clk_sel_d;
    logic       edit_abort_q, edit_abort_d;
    logic       pend_q, pend_d;
    logic       pend_clk_q, pend_clk_d;

    logic       is_edit;
    logic       blink_clr, blink_done;
    logic       to_clr, to_en, to_done;

    assign is_edit = (state_q == S_EDIT_CLK) || (state_q == S_EDIT_TMR);

    assign blink_clr = !is_edit || next_pls;
    assign to_en     = (state_q != S_IDLE);
    assign to_clr    = (state_q == S_IDLE) || (state_d != state_q) || usr_activity
                       || (is_edit && next_pls);

    edit_tick_cnt #(.N(BLINK_DIV)) u_blink_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (blink_clr),
        .en    (is_edit),
        .done  (blink_done)
    );

    edit_tick_cnt #(.N(TIMEOUT_CYC)) u_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (to_clr),
        .en    (to_en),
        .done  (to_done)
    );

    always_comb begin
        state_d      = state_q;
        en_escr_d    = en_escr_q;
        en_clock_d   = en_clock_q;
        field_sel_d  = field_sel_q;
        blink_d      = blink_q;
        wr_req_d     = wr_req_q;
        wr_clk_sel_d = wr_clk_sel_q;
        edit_abort_d = 1'b0;
        pend_d       = pend_q;
        pend_clk_d   = pend_clk_q;

        case (state_q)
            S_IDLE: begin
                en_escr_d    = 1'b0;
                en_clock_d   = 1'b0;
                field_sel_d  = F_SEG;
                blink_d      = 1'b0;
                wr_req_d     = 1'b0;
                wr_clk_sel_d = 1'b0;
                // Latest request wins; clock wins a same-cycle tie.
                if (prog_clk_pls || prog_tmr_pls) begin
                    pend_d     = 1'b1;
                    pend_clk_d = prog_clk_pls;
                end
                if (pend_d && !rtc_busy) begin
                    state_d    = pend_clk_d ? S_EDIT_CLK : S_EDIT_TMR;
                    en_escr_d  = 1'b1;
                    en_clock_d = pend_clk_d;
                    blink_d    = 1'b1;
                    pend_d     = 1'b0;
                    pend_clk_d = 1'b0;
                end
            end

            S_EDIT_CLK, S_EDIT_TMR: begin
                if (to_done || cancel_pls) begin
                    state_d      = S_IDLE;
                    edit_abort_d = 1'b1;
                    en_escr_d    = 1'b0;
                    en_clock_d   = 1'b0;
                    field_sel_d  = F_SEG;
                    blink_d      = 1'b0;
                end else if (ok_pls) begin
                    state_d      = S_COMMIT;
                    wr_req_d     = 1'b1;
                    wr_clk_sel_d = en_clock_q;
                    blink_d      = 1'b1;
                end else if (next_pls) begin
                    field_sel_d = next_field(field_sel_q, state_q == S_EDIT_CLK);
                    blink_d     = 1'b1;
                end else if (blink_done) begin
                    blink_d = ~blink_q;
                end
            end

            S_COMMIT: begin
                blink_d = 1'b1;
                // A timeout outranks a same-cycle ack: the session is reported as aborted.
                if (to_done || wr_ack) begin
                    state_d      = S_IDLE;
                    edit_abort_d = to_done;
                    en_escr_d    = 1'b0;
                    en_clock_d   = 1'b0;
                    field_sel_d  = F_SEG;
                    blink_d      = 1'b0;
                    wr_req_d     = 1'b0;
                    wr_clk_sel_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            en_escr_q    <= 1'b0;
            en_clock_q   <= 1'b0;
            field_sel_q  <= F_SEG;
            blink_q      <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_clk_sel_q <= 1'b0;
            edit_abort_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_clk_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_escr_q    <= en_escr_d;
            en_clock_q   <= en_clock_d;
            field_sel_q  <= field_sel_d;
            blink_q      <= blink_d;
            wr_req_q     <= wr_req_d;
            wr_clk_sel_q <= wr_clk_sel_d;
            edit_abort_q <= edit_abort_d;
            pend_q       <= pend_d;
            pend_clk_q   <= pend_clk_d;
        end
    end

    assign En_Escr    = en_escr_q;
    assign En_clock   = en_clock_q;
    assign field_sel  = field_sel_q;
    assign blink      = blink_q;
    assign wr_req     = wr_req_q;
    assign wr_clk_sel = wr_clk_sel_q;
    assign edit_abort = edit_abort_q;

endmodule

// File: tb/tb_edit_mode_ctrl.sv
// Directed bench for edit_mode_ctrl with BLINK_DIV=4, TIMEOUT_CYC=20.
// Outputs are packed as {En_Escr, En_clock, field_sel, blink, wr_req, wr_clk_sel, edit_abort}.
module tb_edit_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       prog_clk_pls = 1'b0;
    logic       prog_tmr_pls = 1'b0;
    logic       next_pls = 1'b0;
    logic       ok_pls = 1'b0;
    logic       cancel_pls = 1'b0;
    logic       usr_activity = 1'b0;
    logic       rtc_busy = 1'b0;
    logic       wr_ack = 1'b0;
    logic       En_Escr, En_clock, blink, wr_req, wr_clk_sel, edit_abort;
    logic [2:0] field_sel;
    logic [8:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edit_mode_ctrl #(.BLINK_DIV(4), .TIMEOUT_CYC(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .prog_clk_pls (prog_clk_pls),
        .prog_tmr_pls (prog_tmr_pls),
        .next_pls     (next_pls),
        .ok_pls       (ok_pls),
        .cancel_pls   (cancel_pls),
        .usr_activity (usr_activity),
        .rtc_busy     (rtc_busy),
        .wr_ack       (wr_ack),
        .En_Escr      (En_Escr),
        .En_clock     (En_clock),
        .field_sel    (field_sel),
        .blink        (blink),
        .wr_req       (wr_req),
        .wr_clk_sel   (wr_clk_sel),
        .edit_abort   (edit_abort)
    );

    assign obs = {En_Escr, En_clock, field_sel, blink, wr_req, wr_clk_sel, edit_abort};

    function automatic logic [8:0] ev(input logic e, input logic c, input logic [2:0] f,
                                      input logic b, input logic r, input logic s, input logic a);
        return {e, c, f, b, r, s, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        prog_clk_pls = 1'b0;
        prog_tmr_pls = 1'b0;
        next_pls     = 1'b0;
        ok_pls       = 1'b0;
        cancel_pls   = 1'b0;
        usr_activity = 1'b0;
        wr_ack       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs !== 9'h000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'h000);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 9'h000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want %b", obs, 9'h000);
        end
    endtask

    task automatic test_clk_edit_commit();
        logic [2:0] seq [7];
        logic [8:0] exp_v;
        seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        prog_clk_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(1, 1, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL clk_entry: got %b want %b", obs, exp_v); end
        repeat (3) tick();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL blink_hold_e3: got %b want %b", obs, exp_v); end
        tick();
        exp_v = ev(1, 1, 3'd0, 0, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL blink_off_e4: got %b want %b", obs, exp_v); end
        repeat (3) tick();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL blink_off_e7: got %b want %b", obs, exp_v); end
        tick();
        exp_v = ev(1, 1, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL blink_on_e8: got %b want %b", obs, exp_v); end
        for (int i = 0; i < 7; i++) begin
            next_pls = 1'b1;
            tick();
            clear_pulses();
            exp_v = ev(1, 1, seq[i], 1, 0, 0, 0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL clk_next_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        ok_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(1, 1, 3'd1, 1, 1, 1, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL commit_req: got %b want %b", obs, exp_v); end
        next_pls = 1'b1;
        cancel_pls = 1'b1;
        tick();
        clear_pulses();
        tick();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL commit_hold: got %b want %b", obs, exp_v); end
        wr_ack = 1'b1;
        tick();
        clear_pulses();
        n_cmp++;
        if (obs !== 9'h000) begin n_err++; $display("FAIL commit_ack: got %b want %b", obs, 9'h000); end
    endtask

    task automatic test_tmr_busy();
        logic [2:0] seq [4];
        logic [8:0] exp_v;
        seq = '{3'd1, 3'd2, 3'd0, 3'd1};
        rtc_busy = 1'b1;
        prog_tmr_pls = 1'b1;
        tick();
        clear_pulses();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs !== 9'h000) begin
                n_err++;
                $display("FAIL busy_hold_%0d: got %b want %b", i, obs, 9'h000);
            end
            if (i < 4) tick();
        end
        rtc_busy = 1'b0;
        tick();
        exp_v = ev(1, 0, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL tmr_entry: got %b want %b", obs, exp_v); end
        for (int i = 0; i < 4; i++) begin
            next_pls = 1'b1;
            tick();
            clear_pulses();
            exp_v = ev(1, 0, seq[i], 1, 0, 0, 0);
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL tmr_next_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        cancel_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(0, 0, 3'd0, 0, 0, 0, 1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL cancel_abort: got %b want %b", obs, exp_v); end
        tick();
        n_cmp++;
        if (obs !== 9'h000) begin n_err++; $display("FAIL abort_one_cycle: got %b want %b", obs, 9'h000); end
    endtask

    task automatic test_ok_cancel();
        logic [8:0] exp_v;
        prog_clk_pls = 1'b1;
        tick();
        clear_pulses();
        prog_tmr_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(1, 1, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL prog_ignored: got %b want %b", obs, exp_v); end
        ok_pls = 1'b1;
        cancel_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(0, 0, 3'd0, 0, 0, 0, 1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ok_cancel: got %b want %b", obs, exp_v); end
        tick();
        n_cmp++;
        if (obs !== 9'h000) begin n_err++; $display("FAIL no_reentry: got %b want %b", obs, 9'h000); end
    endtask

    task automatic test_commit_timeout();
        logic [8:0] exp_v;
        prog_tmr_pls = 1'b1;
        tick();
        clear_pulses();
        next_pls = 1'b1;
        tick();
        clear_pulses();
        ok_pls = 1'b1;
        next_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(1, 0, 3'd1, 1, 1, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL ok_next_commit: got %b want %b", obs, exp_v); end
        repeat (19) tick();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL commit_c19: got %b want %b", obs, exp_v); end
        wr_ack = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(0, 0, 3'd0, 0, 0, 0, 1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_beats_ack: got %b want %b", obs, exp_v); end
        tick();
    endtask

    task automatic test_timeout();
        logic [8:0] exp_v;
        prog_tmr_pls = 1'b1;
        tick();
        clear_pulses();
        repeat (19) tick();
        exp_v = ev(1, 0, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL tmr_alive_e19: got %b want %b", obs, exp_v); end
        tick();
        exp_v = ev(0, 0, 3'd0, 0, 0, 0, 1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL timeout_e20: got %b want %b", obs, exp_v); end
        tick();
        prog_tmr_pls = 1'b1;
        tick();
        clear_pulses();
        repeat (14) tick();
        usr_activity = 1'b1;
        tick();
        clear_pulses();
        repeat (19) tick();
        exp_v = ev(1, 0, 3'd0, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL activity_alive_e34: got %b want %b", obs, exp_v); end
        tick();
        exp_v = ev(0, 0, 3'd0, 0, 0, 0, 1);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL activity_timeout_e35: got %b want %b", obs, exp_v); end
        tick();
    endtask

    task automatic test_async_reset();
        logic [8:0] exp_v;
        prog_clk_pls = 1'b1;
        tick();
        clear_pulses();
        next_pls = 1'b1;
        tick();
        clear_pulses();
        exp_v = ev(1, 1, 3'd1, 1, 0, 0, 0);
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL pre_reset_edit: got %b want %b", obs, exp_v); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 9'h000) begin n_err++; $display("FAIL async_reset: got %b want %b", obs, 9'h000); end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (obs !== 9'h000) begin n_err++; $display("FAIL post_reset_idle: got %b want %b", obs, 9'h000); end
    endtask

    initial begin
        test_reset();
        test_clk_edit_commit();
        test_tmr_busy();
        test_ok_cancel();
        test_commit_timeout();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
